// File: rtl/countdown_ctrl_pkg.sv
// countdown_ctrl_pkg: shared FSM state encoding and BCD digit width for the countdown block.
// Rev 1.0
`default_nettype none

`ifndef BCD_BIT_WIDTH
`define BCD_BIT_WIDTH 4
`endif

package countdown_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// tick_gen: prescaler counting 0..TICK_DIV-1 while enabled; tick marks the terminal count.
// Rev 1.0
`default_nettype none

module tick_gen #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  assign tick = en && (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: IDLE/RUN/PAUSE/DONE controller driving a BCD downcounter chain.
// Rev 1.0 -- optional DONE_BLINK_EN makes alarm blink once per tick while in DONE.
`default_nettype none

`ifndef BCD_BIT_WIDTH
`define BCD_BIT_WIDTH 4
`endif

module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_pause,
  input  logic                      clear,
  input  logic [`BCD_BIT_WIDTH-1:0] digit0,
  input  logic [`BCD_BIT_WIDTH-1:0] digit1,
  input  logic [`BCD_BIT_WIDTH-1:0] digit2,
  input  logic [`BCD_BIT_WIDTH-1:0] digit3,
  output logic                      stop,
  output logic                      decrease,
  output logic                      done,
  output logic                      alarm,
  output logic [1:0]                state
);

  state_t state_q, state_d;
  logic   dec_q, dec_d;
  logic   ps_clr, ps_en, tick;
  logic   all_zero;

  assign all_zero = ~|{digit3, digit2, digit1, digit0};

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (ps_clr),
    .en   (ps_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dec_d   = 1'b0;
    ps_clr  = 1'b0;
    ps_en   = 1'b0;
    stop    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stop   = 1'b1;
        ps_clr = 1'b1;
        if (start_pause) state_d = all_zero ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        // Prescaler keeps counting on the pause cycle, so a tick there is simply dropped.
        ps_en = 1'b1;
        if (start_pause) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          if (all_zero) state_d = ST_DONE;
          else          dec_d   = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (start_pause) state_d = ST_RUN;
      end
      ST_DONE: begin
        done = 1'b1;
`ifdef DONE_BLINK_EN
        ps_en = 1'b1;
`else
        ps_clr = 1'b1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d = ST_IDLE;
      dec_d   = 1'b0;
      ps_clr  = 1'b1;
    end
  end

`ifdef DONE_BLINK_EN
  logic alarm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q <= 1'b0;
    end else if (state_d != ST_DONE) begin
      alarm_q <= 1'b0;
    end else if (state_q != ST_DONE) begin
      alarm_q <= 1'b1;
    end else if (tick) begin
      alarm_q <= ~alarm_q;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = done;
`endif

  assign decrease = dec_q;
  assign state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: scoreboard bench with a behavioural model and a BCD downcounter chain, TICK_DIV=4.
// Rev 1.0
`default_nettype none

`ifndef BCD_BIT_WIDTH
`define BCD_BIT_WIDTH 4
`endif

module tb_countdown_ctrl;

  localparam int unsigned TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_pause = 1'b0;
  logic clear = 1'b0;
  logic [15:0] digits_q = 16'h0000;
  logic [15:0] init_v = 16'h0030;
  logic stop, decrease, done, alarm;
  logic [1:0] state;

  always #5 clk = ~clk;

  countdown_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_pause (start_pause),
    .clear       (clear),
    .digit0      (digits_q[3:0]),
    .digit1      (digits_q[7:4]),
    .digit2      (digits_q[11:8]),
    .digit3      (digits_q[15:12]),
    .stop        (stop),
    .decrease    (decrease),
    .done        (done),
    .alarm       (alarm),
    .state       (state)
  );

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] != 4'd0) begin
        r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
        break;
      end
      r[i*4 +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Downcounter chain stimulus: reloads on stop, decrements on decrease.
  always @(posedge clk) begin
    if (stop)          digits_q <= init_v;
    else if (decrease) digits_q <= bcd_dec(digits_q);
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int first_dec = -1;
  int dec_count = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference model, evaluated on pre-edge inputs.
  logic [1:0] m_state = 2'd0;
  int         m_cnt = 0;
  logic       m_dec = 1'b0;
  logic       m_alarm = 1'b0;
`ifdef DONE_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  task automatic model_step();
    logic zero, tk;
    zero = (digits_q == 16'h0000);
    tk = (m_state == 2'd1 || (BLINK && m_state == 2'd3)) && (m_cnt == TICK_DIV - 1);
    if (rst || clear) begin
      m_state = 2'd0; m_cnt = 0; m_dec = 1'b0; m_alarm = 1'b0;
    end else begin
      m_dec = 1'b0;
      case (m_state)
        2'd0: begin
          m_cnt = 0;
          if (start_pause) begin
            m_state = zero ? 2'd3 : 2'd1;
            m_alarm = zero;
          end
        end
        2'd1: begin
          m_cnt = (m_cnt + 1) % TICK_DIV;
          if (start_pause) m_state = 2'd2;
          else if (tk && zero) begin m_state = 2'd3; m_alarm = 1'b1; end
          else if (tk) m_dec = 1'b1;
        end
        2'd2: if (start_pause) m_state = 2'd1;
        default: begin
          if (BLINK) begin
            m_cnt = (m_cnt + 1) % TICK_DIV;
            if (tk) m_alarm = ~m_alarm;
          end else m_cnt = 0;
        end
      endcase
    end
    exp_q.push_back({m_state, m_state == 2'd0, m_dec, m_state == 2'd3,
                     BLINK ? m_alarm : (m_state == 2'd3)});
  endtask

  task automatic cycle(input logic sp, input logic cl, input logic r);
    logic [5:0] e;
    start_pause = sp; clear = cl; rst = r;
    model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (decrease) begin
      dec_count++;
      if (first_dec < 0) first_dec = cyc;
    end
    if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
    else begin
      e = exp_q.pop_front();
      check("outs", {26'd0, state, stop, decrease, done, alarm}, {26'd0, e});
    end
  endtask

  task automatic run_to_tick(input int budget);
    for (int i = 0; i < budget && !(m_state == 2'd1 && m_cnt == TICK_DIV - 1); i++)
      cycle(1'b0, 1'b0, 1'b0);
    check("tick_wait", {30'd0, state}, 32'd1);
  endtask

  int t0;

  initial begin
    @(negedge clk);
    cycle(0, 0, 1); cycle(0, 0, 1);
    check("rst_state", state, 0); check("rst_stop", stop, 1); check("rst_dec", decrease, 0);
    check("rst_done", done, 0);   check("rst_alarm", alarm, 0);
    cycle(0, 0, 0);

    // Start with digits 0,3,0,0 (value 30) and measure first decrease latency.
    first_dec = -1; dec_count = 0; t0 = cyc;
    cycle(1, 0, 0);
    check("run_state", state, 1); check("run_stop", stop, 0);
    repeat (12) cycle(0, 0, 0);
    check("first_dec_lat", first_dec - t0, 5);

    // Pause on the tick cycle, hold, then resume.
    run_to_tick(8);
    cycle(1, 0, 0);
    check("pause_state", state, 2);
    repeat (6) cycle(0, 0, 0);
    check("pause_no_dec", decrease, 0);
    first_dec = -1; t0 = cyc;
    cycle(1, 0, 0);
    repeat (6) cycle(0, 0, 0);
    check("resume_lat", first_dec - t0, 5);

    // Clear wins over simultaneous start_pause.
    cycle(1, 1, 0);
    check("clr_state", state, 0); check("clr_stop", stop, 1);
    cycle(0, 0, 0);

    // Full countdown from 30 to DONE.
    dec_count = 0;
    cycle(1, 0, 0);
    for (int i = 0; i < 200 && m_state != 2'd3; i++) cycle(0, 0, 0);
    check("reached_done", state, 3); check("done_flag", done, 1);
    check("dec_total", dec_count, 30); check("digits_zero", digits_q, 0);
    repeat (16) cycle(0, 0, 0);
`ifndef DONE_BLINK_EN
    check("done_alarm_steady", alarm, 1);
`endif
    cycle(1, 0, 0);
    check("done_ignores_sp", state, 3);
    check("done_no_dec", dec_count, 30);
    cycle(0, 1, 0);
    check("done_clear", state, 0);

    // Start with all-zero digits goes straight to DONE.
    init_v = 16'h0000;
    cycle(0, 0, 0);
    dec_count = 0;
    cycle(1, 0, 0);
    check("zero_start_done", state, 3);
    repeat (8) cycle(0, 0, 0);
    check("zero_no_dec", dec_count, 0);

    // Reset on the tick cycle drops the pending decrease.
    cycle(0, 1, 0);
    init_v = 16'h0012;
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    run_to_tick(8);
    cycle(0, 0, 1);
    check("rst_tick_dec", decrease, 0); check("rst_tick_state", state, 0);
    cycle(0, 0, 0);
    check("rst_tick_dec2", decrease, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
